ps2_scan_decoder: RTL and testbench
===================================

Name: ps2_scan_decoder

Overview:
- Sits directly downstream of ps2_keyboard. Pops bytes from its FIFO through the ready/nextdata_n handshake and parses PS/2 set-2 make/break/extended sequences.
- Presents the currently held key, a one-cycle make/break event, and a 2-digit BCD count of distinct key presses.
- Outputs drive keycode_to_ascii and the bcd7seg displays in top: hex0/1 show the key, hex4/5 show the count, and displays blank when key_valid=0.

Parameters:
IGNORE_REPEAT, 1, 1: a typematic repeat (same make code while held) produces no make_pulse and no count increment; 0: every repeat counts as a new press.

Ports:
clk  in  1  system clock, same domain as ps2_keyboard
rst  in  1  synchronous active-high reset
data  in  8  FIFO head byte from ps2_keyboard; valid while ready=1
ready  in  1  ps2_keyboard FIFO non-empty
overflow  in  1  ps2_keyboard FIFO overflow flag
nextdata_n  out  1  pop request to ps2_keyboard, active low, registered
key_code  out  8  scan code of the held or last held key
key_ext  out  1  key_code was E0-prefixed
key_valid  out  1  a key is currently held
make_pulse  out  1  one-cycle strobe on a counted press
break_pulse  out  1  one-cycle strobe on release of the held key
press_count  out  8  BCD count of presses, [7:4] tens, [3:0] units
ovf_seen  out  1  sticky: overflow was observed

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous and active-high.
- Reset values: nextdata_n=1; key_code=8'h00; key_ext=0; key_valid=0; make_pulse=0; break_pulse=0; press_count=8'h00; ovf_seen=0; E0 and F0 prefix flags cleared; FSM in IDLE.
- Handshake FSM (two states):
  - IDLE: if ready=1 and nextdata_n=1, capture data into byte_r, drive nextdata_n<=0, go to POP. Otherwise stay, with nextdata_n=1.
  - POP: nextdata_n<=1, process byte_r (parse rules below), go to IDLE.
  - The FIFO advances on the edge that ends the POP cycle, so ready is valid again in the following IDLE cycle.
  - Throughput: at most one byte per 2 cycles. nextdata_n is never low for 2 consecutive cycles.
- Parse rules (applied in POP):
  - byte_r=E0: set ext flag. No output change.
  - byte_r=F0: set brk flag. No output change. A repeated F0 keeps brk set.
  - Any other byte with brk=1 (break): if key_valid=1, byte_r==key_code and ext==key_ext, then key_valid<=0 and break_pulse<=1, with key_code and key_ext retained. Otherwise the break is ignored. Both flags clear.
  - Any other byte with brk=0 (make):
    - If key_valid=1, byte_r==key_code, ext==key_ext and IGNORE_REPEAT=1: treat as a repeat; no output change.
    - Otherwise: key_code<=byte_r, key_ext<=ext, key_valid<=1, make_pulse<=1, and press_count increments.
    - Both flags clear.
  - A make of a different key while one is held replaces it; only the newest key is tracked.
- press_count arithmetic: BCD. If units==9, units<=0 and tens increments; 99 wraps to 00. No binary intermediate value appears on the port.
- Pulses: make_pulse and break_pulse are high exactly one cycle (the cycle after POP) and are mutually exclusive.
- ovf_seen: set on any cycle with overflow=1. Cleared only by rst. Parsing continues after overflow; no resync is attempted.
- Reset mid-operation: rst while in POP cancels processing. That byte is discarded even though the FIFO pops it on the same edge. All outputs return to their reset values on the next cycle.
- rst and ready both high: rst wins; no capture.

Test Plan:
- Simple press/release: feed 1C, F0, 1C with ready held → make_pulse once with key_code=1C, key_valid=1, press_count=01; then break_pulse once, key_valid=0, key_code still 1C. Check nextdata_n pulses low exactly 3 times, never on 2 consecutive cycles.
- Extended key: feed E0 75, E0 F0 75 → key_code=75, key_ext=1, count +1; release clears key_valid. Then feed F0 75 without E0 → ignored, no break_pulse.
- Typematic: feed 1C 1C 1C → with IGNORE_REPEAT=1, count=01 and one make_pulse; with IGNORE_REPEAT=0, count=03 and three make_pulses.
- BCD wrap: 100 press/release pairs of 2B → count steps 09→10 at the 10th press, 99 at the 99th, wraps to 00 at the 100th.
- Key rollover: feed 1C, 32, F0 1C → key_code=32 and key_valid stays 1 (break of a non-current key ignored); F0 32 then clears key_valid.
- Reset and overflow: pulse overflow for 1 cycle → ovf_seen=1 and stays 1. Assert rst during a POP cycle holding byte 1C → no make_pulse, all outputs at reset values, ovf_seen=0.

Source files
------------

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: pops PS/2 set-2 bytes from ps2_keyboard and tracks held key, press events and a BCD press count
module ps2_scan_decoder #(
    parameter bit IGNORE_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_valid,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] press_count,
    output logic       ovf_seen
);
    typedef enum logic {IDLE, POP} state_t;
    state_t     state, state_n;
    logic [7:0] byte_r, byte_n;
    logic       ext, ext_n, brk, brk_n;
    logic       nextdata_nn;
    logic [7:0] key_code_n, press_count_n, bcd_inc;
    logic       key_ext_n, key_valid_n, make_n, break_n, ovf_n;
    logic       same_key;
    assign same_key = key_valid && byte_r == key_code && ext == key_ext;
    assign bcd_inc  = (press_count[3:0] == 4'd9)
                    ? {(press_count[7:4] == 4'd9) ? 4'd0 : press_count[7:4] + 4'd1, 4'd0}
                    : {press_count[7:4], press_count[3:0] + 4'd1};
    // handshake and parse: decide next register values; outputs change only after a POP cycle
    always_comb begin
        state_n       = state;
        byte_n        = byte_r;
        ext_n         = ext;
        brk_n         = brk;
        nextdata_nn   = 1'b1;
        key_code_n    = key_code;
        key_ext_n     = key_ext;
        key_valid_n   = key_valid;
        make_n        = 1'b0;
        break_n       = 1'b0;
        press_count_n = press_count;
        ovf_n         = ovf_seen | overflow;
        if (state == IDLE) begin
            if (ready && nextdata_n) begin
                byte_n      = data;
                nextdata_nn = 1'b0;
                state_n     = POP;
            end
        end else begin
            state_n = IDLE;
            if (byte_r == 8'hE0) begin
                ext_n = 1'b1;
            end else if (byte_r == 8'hF0) begin
                brk_n = 1'b1;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (brk) begin
                    if (same_key) begin
                        key_valid_n = 1'b0;
                        break_n     = 1'b1;
                    end
                end else if (!(same_key && IGNORE_REPEAT)) begin
                    key_code_n    = byte_r;
                    key_ext_n     = ext;
                    key_valid_n   = 1'b1;
                    make_n        = 1'b1;
                    press_count_n = bcd_inc;
                end
            end
        end
    end
    // state register; reset discards any byte being processed
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_r      <= 8'h00;
            ext         <= 1'b0;
            brk         <= 1'b0;
            nextdata_n  <= 1'b1;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            press_count <= 8'h00;
            ovf_seen    <= 1'b0;
        end else begin
            state       <= state_n;
            byte_r      <= byte_n;
            ext         <= ext_n;
            brk         <= brk_n;
            nextdata_n  <= nextdata_nn;
            key_code    <= key_code_n;
            key_ext     <= key_ext_n;
            key_valid   <= key_valid_n;
            make_pulse  <= make_n;
            break_pulse <= break_n;
            press_count <= press_count_n;
            ovf_seen    <= ovf_n;
        end
    end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: checks both IGNORE_REPEAT settings against a byte-level key model fed from a FIFO queue
module tb_ps2_scan_decoder;
    logic       clk = 1'b0, rst = 1'b1, ready = 1'b0, overflow = 1'b0;
    logic [7:0] data = 8'h00;
    logic       o0_nd, o0_ke, o0_kv, o0_mk, o0_bk, o0_ovf;
    logic       o1_nd, o1_ke, o1_kv, o1_mk, o1_bk, o1_ovf;
    logic [7:0] o0_kc, o0_pc, o1_kc, o1_pc;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.IGNORE_REPEAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(o0_nd), .key_code(o0_kc), .key_ext(o0_ke), .key_valid(o0_kv),
        .make_pulse(o0_mk), .break_pulse(o0_bk), .press_count(o0_pc), .ovf_seen(o0_ovf));
    ps2_scan_decoder #(.IGNORE_REPEAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(o1_nd), .key_code(o1_kc), .key_ext(o1_ke), .key_valid(o1_kv),
        .make_pulse(o1_mk), .break_pulse(o1_bk), .press_count(o1_pc), .ovf_seen(o1_ovf));

    int         total = 0, bad = 0;
    logic [7:0] q[$];
    bit         m_ext[2], m_brk[2], m_valid[2], m_kext[2], m_mk[2], m_bk[2];
    logic [7:0] m_code[2];
    int         m_cnt[2];
    bit         m_ovf = 1'b0, m_nd = 1'b1;
    int         mk_seen[2], bk_seen[2], nd_lows;
    bit         arm_rst = 1'b0;
    logic [7:0] pool[6] = '{8'hE0, 8'hF0, 8'h1C, 8'h32, 8'h75, 8'h2B};

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic void mreset();
        for (int p = 0; p < 2; p++) begin
            m_ext[p] = 0; m_brk[p] = 0; m_valid[p] = 0; m_kext[p] = 0;
            m_mk[p] = 0; m_bk[p] = 0; m_code[p] = 8'h00; m_cnt[p] = 0;
        end
        m_ovf = 0;
        m_nd  = 1;
    endfunction

    // one popped byte applied to the key model of dut p (p=0 ignores repeats)
    function automatic void parse(input int p, input logic [7:0] b);
        bit same;
        if (b == 8'hE0) m_ext[p] = 1;
        else if (b == 8'hF0) m_brk[p] = 1;
        else begin
            same = m_valid[p] && b == m_code[p] && m_ext[p] == m_kext[p];
            if (m_brk[p]) begin
                if (same) begin
                    m_valid[p] = 0;
                    m_bk[p] = 1;
                end
            end else if (!(same && p == 0)) begin
                m_code[p]  = b;
                m_kext[p]  = m_ext[p];
                m_valid[p] = 1;
                m_mk[p]    = 1;
                m_cnt[p]   = (m_cnt[p] + 1) % 100;
            end
            m_ext[p] = 0;
            m_brk[p] = 0;
        end
    endfunction

    // one cycle: compare outputs to the model, then act as the keyboard FIFO and advance the model
    task automatic step(input bit r_in, input bit ov);
        bit         r, popped, nd, ke, kv, mk, bk, of;
        logic [7:0] b, kc, pc;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            nd = p ? o1_nd : o0_nd;  ke = p ? o1_ke : o0_ke;  kv = p ? o1_kv : o0_kv;
            mk = p ? o1_mk : o0_mk;  bk = p ? o1_bk : o0_bk;  of = p ? o1_ovf : o0_ovf;
            kc = p ? o1_kc : o0_kc;  pc = p ? o1_pc : o0_pc;
            chk($sformatf("nextdata_n%0d", p), nd, m_nd);
            chk($sformatf("key_code%0d", p), kc, m_code[p]);
            chk($sformatf("key_ext%0d", p), ke, m_kext[p]);
            chk($sformatf("key_valid%0d", p), kv, m_valid[p]);
            chk($sformatf("make_pulse%0d", p), mk, m_mk[p]);
            chk($sformatf("break_pulse%0d", p), bk, m_bk[p]);
            chk($sformatf("press_count%0d", p), pc, {4'(m_cnt[p] / 10), 4'(m_cnt[p] % 10)});
            chk($sformatf("ovf_seen%0d", p), of, m_ovf);
            mk_seen[p] += int'(mk);
            bk_seen[p] += int'(bk);
        end
        if (!o0_nd) nd_lows++;
        r = r_in;
        if (arm_rst && !o0_nd) begin
            r = 1;
            arm_rst = 0;
        end
        popped = 0;
        b = 8'h00;
        if (!o0_nd && q.size() > 0) begin
            b = q.pop_front();
            popped = 1;
        end
        ready    = q.size() > 0;
        data     = ready ? q[0] : 8'($urandom);
        rst      = r;
        overflow = ov;
        for (int p = 0; p < 2; p++) begin
            m_mk[p] = 0;
            m_bk[p] = 0;
        end
        if (r) mreset();
        else begin
            m_nd  = !(o0_nd && ready);
            m_ovf = m_ovf | ov;
            if (popped) for (int p = 0; p < 2; p++) parse(p, b);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || !o0_nd) && g < 300) begin
            step(0, 0);
            g++;
        end
        chk("drain_timeout", int'(g < 300), 1);
        step(0, 0);
    endtask

    task automatic clr();
        mk_seen = '{0, 0};
        bk_seen = '{0, 0};
        nd_lows = 0;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        q.push_back(a); q.push_back(b); q.push_back(c);
    endtask

    initial begin
        mreset();
        step(1, 0); step(1, 0); step(0, 0);
        chk("rst_key_code", o0_kc, 8'h00);
        chk("rst_nextdata_n", o0_nd, 1);
        chk("rst_press_count", o0_pc, 8'h00);
        chk("rst_key_valid", o0_kv, 0);
        clr();
        push3(8'h1C, 8'hF0, 8'h1C);
        drain();
        chk("simple_makes", mk_seen[0], 1);
        chk("simple_breaks", bk_seen[0], 1);
        chk("simple_pops", nd_lows, 3);
        chk("simple_key_valid", o0_kv, 0);
        chk("simple_key_code", o0_kc, 8'h1C);
        chk("simple_count", o0_pc, 8'h01);
        clr();
        q.push_back(8'hE0); q.push_back(8'h75);
        drain();
        chk("ext_key_code", o0_kc, 8'h75);
        chk("ext_key_ext", o0_ke, 1);
        chk("ext_key_valid", o0_kv, 1);
        chk("ext_count", o0_pc, 8'h02);
        q.push_back(8'hE0); q.push_back(8'hF0); q.push_back(8'h75);
        drain();
        chk("ext_release", o0_kv, 0);
        chk("ext_breaks", bk_seen[0], 1);
        clr();
        q.push_back(8'hF0); q.push_back(8'h75);
        drain();
        chk("plain_break_ignored", bk_seen[0], 0);
        clr();
        push3(8'h1C, 8'h1C, 8'h1C);
        drain();
        chk("repeat_makes_ign", mk_seen[0], 1);
        chk("repeat_makes_cnt", mk_seen[1], 3);
        chk("repeat_count_ign", o0_pc, 8'h03);
        chk("repeat_count_cnt", o1_pc, 8'h05);
        q.push_back(8'hF0); q.push_back(8'h1C);
        drain();
        q.push_back(8'h1C); push3(8'h32, 8'hF0, 8'h1C);
        drain();
        chk("rollover_key_code", o0_kc, 8'h32);
        chk("rollover_key_valid", o0_kv, 1);
        q.push_back(8'hF0); q.push_back(8'h32);
        drain();
        chk("rollover_release", o0_kv, 0);
        step(1, 0);
        for (int i = 1; i <= 100; i++) begin
            push3(8'h2B, 8'hF0, 8'h2B);
            drain();
            if (i == 9 || i == 10 || i == 99 || i == 100)
                chk($sformatf("wrap_%0d", i), o0_pc,
                    i == 9 ? 8'h09 : i == 10 ? 8'h10 : i == 99 ? 8'h99 : 8'h00);
        end
        step(0, 1);
        repeat (3) step(0, 0);
        chk("ovf_sticky", o0_ovf, 1);
        clr();
        arm_rst = 1;
        q.push_back(8'h1C);
        drain();
        chk("rst_pop_fired", arm_rst, 0);
        chk("rst_pop_makes", mk_seen[0], 0);
        chk("rst_pop_ovf", o0_ovf, 0);
        chk("rst_pop_key_code", o0_kc, 8'h00);
        chk("rst_pop_key_valid", o0_kv, 0);
        repeat (4000) begin
            if (q.size() < 3 && $urandom_range(0, 2) == 0)
                q.push_back($urandom_range(0, 4) != 0 ? pool[$urandom_range(0, 5)] : 8'($urandom));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
